// File: rtl/weight_stream_ctrl.sv
// weight_stream_ctrl: sequences a fixed-latency weight ROM into a backpressured valid/ready stream
module weight_stream_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH+1),
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [REPEAT_WIDTH-1:0] num_repeats,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                  state_q, state_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic [REPEAT_WIDTH-1:0] rep_cnt_q, rep_cnt_d, rep_n_q, rep_n_d;
  logic [READ_LATENCY-1:0] flight_q, flight_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    issue, wrap, push, pop;
  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign rom_addr       = rom_addr_q;
  assign data_out       = mem_q[rd_q];
  assign data_out_valid = cnt_q != '0;
  // Controller: issue reads while credits remain (in-flight reads plus buffered words never exceed the buffer), track passes
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    rom_addr_d = rom_addr_q;
    rep_cnt_d  = rep_cnt_q;
    rep_n_d    = rep_n_q;
    issue      = state_q == RUN && 32'($countones(flight_q)) + 32'(cnt_q) < 32'(FIFO_DEPTH);
    wrap       = rom_addr_q == ADDR_WIDTH'(DEPTH-1);
    if (state_q == IDLE && start) begin
      done_d = num_repeats == '0;
      if (num_repeats != '0) begin
        state_d    = RUN;
        rep_n_d    = num_repeats;
        rep_cnt_d  = '0;
        rom_addr_d = '0;
      end
    end
    if (issue) begin
      rom_addr_d = wrap ? '0 : rom_addr_q + 1'b1;
      rep_cnt_d  = wrap ? rep_cnt_q + 1'b1 : rep_cnt_q;
      state_d    = wrap && REPEAT_WIDTH'(rep_cnt_q + 1'b1) == rep_n_q ? DRAIN : state_d;
    end
    if (state_q == DRAIN && flight_q == '0 && cnt_q == '0) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  // Read pipeline tracker and show-ahead output buffer; the flag leaving the tracker marks rom_q valid
  always_comb begin
    push     = flight_q[READ_LATENCY-1];
    pop      = data_out_valid && data_out_ready;
    flight_d = READ_LATENCY'({flight_q, issue});
    mem_d    = mem_q;
    if (push) mem_d[wr_q] = rom_q;
    wr_d  = push ? (wr_q == PW'(FIFO_DEPTH-1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = pop ? (rd_q == PW'(FIFO_DEPTH-1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  // State registers; reset discards in-flight reads and buffered words
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      rep_cnt_q  <= '0;
      rep_n_q    <= '0;
      flight_q   <= '0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      rom_addr_q <= rom_addr_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_n_q    <= rep_n_d;
      flight_q   <= flight_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule
